// File: rtl/imem_loader.sv
`default_nettype none
// imem_loader: streams instruction bytes into SRAM words 0..LENGTH-1, holding the CPU
// in reset until the image is complete and keeping a modulo-2^WIDTH checksum.
module imem_loader #(
  parameter int ADDR   = 4,
  parameter int WIDTH  = 8,
  parameter int LENGTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_data,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR-1:0] LAST = ADDR'(LENGTH - 1);

  state_t          state;
  state_t          state_next;
  logic [ADDR-1:0] count;
  logic            strobe;
  logic            hold;
  logic            accept;
  logic            launch;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          launch     = 1'b1;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && (count == LAST)) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          state_next = LOAD;
          launch     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The CPU is released only once DONE has lasted a full cycle, i.e. after the last strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      checksum <= '0;
      strobe   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      hold     <= 1'b1;
    end else begin
      state  <= state_next;
      strobe <= accept;
      hold   <= !((state == DONE) && (state_next == DONE));
      if (launch) begin
        count    <= '0;
        checksum <= '0;
      end else if (accept) begin
        count    <= count + 1'b1;
        checksum <= checksum + in_data;
        mem_addr <= count;
        mem_data <= in_data;
      end
    end
  end

  assign mem_cs   = strobe;
  assign mem_we   = strobe;
  assign cpu_hold = hold;
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);

endmodule
`default_nettype wire
